arb_mux_nto1: RTL and testbench
===============================

// Module: arb_mux_nto1
// PURPOSE
//  Parametrised N-to-1 datapath multiplexer with one registered output stage and
//  valid/ready handshakes on every input and on the output. Selection is either
//  an external select (MODE 0) or internal round-robin arbitration (MODE 1).
//  Used in the RISC-V datapath where several sources compete for one bus.
// PARAMETERS
//  WIDTH  32  data width of each channel and of the output, in bits
//  N_IN   4   number of input channels, 2..16
//  MODE   0   0 = external select via Sel; 1 = round-robin arbitration, Sel ignored
//  SEL_W  localparam = $clog2(N_IN); width of Sel and Out_Src
// PORTS
//  clk       in   1            rising-edge clock
//  rst       in   1            reset: asynchronous, active-high
//  In_Data   in   N_IN*WIDTH   channel i occupies bits [i*WIDTH +: WIDTH]
//  In_Valid  in   N_IN         channel i presents a beat
//  In_Ready  out  N_IN         channel i beat accepted this cycle (when In_Valid[i])
//  Sel       in   SEL_W        selected channel, MODE 0 only
//  Out_Data  out  WIDTH        registered output data
//  Out_Valid out  1            Out_Data holds a beat
//  Out_Ready in   1            downstream accepts the beat
//  Out_Src   out  SEL_W        index of the channel that supplied Out_Data
// BEHAVIOUR
//  - Reset (async, while rst=1): Out_Valid=0, Out_Data=0, Out_Src=0, In_Ready=0.
//    RR pointer = N_IN-1, so channel 0 has first priority. Reset mid-operation
//    discards the held beat; no partial state survives.
//  - can_load = !Out_Valid | Out_Ready (combinational; In_Ready may depend on Out_Ready).
//  - Grant g:
//      MODE 0: g=Sel if Sel<N_IN, else no grant.
//      MODE 1: g = first i with In_Valid[i], searching ptr+1, ptr+2, ... wrapping mod N_IN.
//  - In_Ready[i] = can_load & grant_exists & (i==g). All other In_Ready bits are 0.
//    MODE 0: In_Ready[Sel] may be 1 while In_Valid[Sel]=0.
//  - Transfer in: In_Valid[g] & In_Ready[g]. On the next edge: Out_Data=In_Data[g],
//    Out_Src=g, Out_Valid=1. MODE 1: ptr=g.
//  - Latency: exactly 1 cycle from input handshake to Out_Valid. Throughput:
//    1 beat/cycle while Out_Ready=1.
//  - Output hold: Out_Valid=1 & Out_Ready=0 -> Out_Data, Out_Src, Out_Valid stable;
//    all In_Ready=0.
//  - Drain: Out_Ready=1 with no transfer in -> Out_Valid=0 next edge. Out_Data keeps
//    its last value (don't-care).
//  - Simultaneous accept + load: the output register is replaced in the same edge;
//    no bubble.
//  - Sel change while the output is stalled has no effect until can_load=1.
//    Sel is sampled only in cycles with can_load=1.
//  - ptr wraps N_IN-1 -> 0. ptr does not move when there is no transfer.
//  - Out_Src is zero-extended when N_IN is not a power of 2. Sel values >= N_IN grant nothing.
// TESTING
//  1 Reset: assert rst mid-stream with Out_Valid=1 -> Out_Valid=0, Out_Data=0,
//    In_Ready=0 immediately, before any clock edge.
//  2 MODE0, N_IN=4, Sel=2, In_Valid=4'b0100, In_Data[2]=32'hDEADBEEF, Out_Ready=1
//    -> In_Ready=4'b0100; next cycle Out_Valid=1, Out_Data=DEADBEEF, Out_Src=2.
//  3 Back-pressure: hold Out_Ready=0 for 3 cycles with Out_Valid=1, change Sel and
//    In_Data -> output stable, In_Ready=0; release -> next beat loads on that edge.
//  4 MODE1: all four In_Valid=1 continuously, Out_Ready=1 -> Out_Src sequence
//    0,1,2,3,0,... one beat/cycle.
//  5 MODE1 fairness: only ch1 and ch3 valid -> Out_Src alternates 1,3,1,3.
//    Drop ch3 -> 1,1,1.
//  6 Out-of-range: N_IN=3, MODE0, Sel=3 -> In_Ready=0, Out_Valid stays 0.
//    Scoreboard: every accepted input beat appears exactly once, in order, per channel.

Source files
------------

// File: rtl/arb_mux_nto1.sv
// N-to-1 valid/ready multiplexer with a single registered output stage.
// Channel choice comes from an external select (MODE 0) or a round-robin arbiter (MODE 1).
module arb_mux_nto1 #(
    parameter  int WIDTH = 32,
    parameter  int N_IN  = 4,
    parameter  int MODE  = 0,
    localparam int SEL_W = $clog2(N_IN)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_IN*WIDTH-1:0] In_Data,
    input  logic [N_IN-1:0]       In_Valid,
    output logic [N_IN-1:0]       In_Ready,
    input  logic [SEL_W-1:0]      Sel,
    output logic [WIDTH-1:0]      Out_Data,
    output logic                  Out_Valid,
    input  logic                  Out_Ready,
    output logic [SEL_W-1:0]      Out_Src
);

    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] grant_idx;
    logic             grant_valid;
    logic             can_load;
    logic             transfer;
    logic [WIDTH-1:0] grant_data;
    int               rr_idx;

    // The output register can take a new beat when empty or being emptied this cycle.
    assign can_load = !Out_Valid || Out_Ready;

    // NOTE: every signal written here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        rr_idx      = 0;
        if (MODE == 0) begin
            if (int'(Sel) < N_IN) begin
                grant_valid = 1'b1;
                grant_idx   = Sel;
            end
        end else begin
            // Scan from farthest to nearest so the channel closest after ptr wins.
            for (int k = N_IN; k >= 1; k--) begin
                rr_idx = int'(ptr) + k;
                if (rr_idx >= N_IN) rr_idx = rr_idx - N_IN;
                if (In_Valid[SEL_W'(rr_idx)]) begin
                    grant_valid = 1'b1;
                    grant_idx   = SEL_W'(rr_idx);
                end
            end
        end
    end

    // Ready is forced low while reset is held so no beat appears accepted.
    always_comb begin
        In_Ready = '0;
        if (!rst && can_load && grant_valid) In_Ready[grant_idx] = 1'b1;
    end

    assign transfer   = In_Ready[grant_idx] && In_Valid[grant_idx];
    assign grant_data = In_Data[int'(grant_idx)*WIDTH +: WIDTH];

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Out_Valid <= 1'b0;
            Out_Data  <= '0;
            Out_Src   <= '0;
            ptr       <= SEL_W'(N_IN - 1);
        end else if (transfer) begin
            Out_Valid <= 1'b1;
            Out_Data  <= grant_data;
            Out_Src   <= grant_idx;
            if (MODE != 0) ptr <= grant_idx;
        end else if (Out_Ready) begin
            Out_Valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_arb_mux_nto1.sv
// Directed bench for arb_mux_nto1: external-select, round-robin and
// non-power-of-two instances checked against hand-computed values.
module tb_arb_mux_nto1;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // a: MODE 0, N_IN 4
    logic [4*W-1:0] a_data;
    logic [3:0]     a_valid, a_ready;
    logic [1:0]     a_sel, a_src;
    logic [W-1:0]   a_odata;
    logic           a_ovalid, a_oready;
    // b: MODE 1, N_IN 4
    logic [4*W-1:0] b_data;
    logic [3:0]     b_valid, b_ready;
    logic [1:0]     b_sel, b_src;
    logic [W-1:0]   b_odata;
    logic           b_ovalid, b_oready;
    // c: MODE 0, N_IN 3
    logic [3*W-1:0] c_data;
    logic [2:0]     c_valid, c_ready;
    logic [1:0]     c_sel, c_src;
    logic [W-1:0]   c_odata;
    logic           c_ovalid, c_oready;

    arb_mux_nto1 #(.WIDTH(W), .N_IN(4), .MODE(0)) u_a (
        .clk(clk), .rst(rst), .In_Data(a_data), .In_Valid(a_valid), .In_Ready(a_ready),
        .Sel(a_sel), .Out_Data(a_odata), .Out_Valid(a_ovalid), .Out_Ready(a_oready),
        .Out_Src(a_src)
    );
    arb_mux_nto1 #(.WIDTH(W), .N_IN(4), .MODE(1)) u_b (
        .clk(clk), .rst(rst), .In_Data(b_data), .In_Valid(b_valid), .In_Ready(b_ready),
        .Sel(b_sel), .Out_Data(b_odata), .Out_Valid(b_ovalid), .Out_Ready(b_oready),
        .Out_Src(b_src)
    );
    arb_mux_nto1 #(.WIDTH(W), .N_IN(3), .MODE(0)) u_c (
        .clk(clk), .rst(rst), .In_Data(c_data), .In_Valid(c_valid), .In_Ready(c_ready),
        .Sel(c_sel), .Out_Data(c_odata), .Out_Valid(c_ovalid), .Out_Ready(c_oready),
        .Out_Src(c_src)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int unsigned cnt [4];

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Channel ch of b carries {ch, beat number} so order per channel is visible.
    function automatic logic [W-1:0] b_word(input int ch);
        return W'(ch * 32'h0100_0000 + int'(cnt[ch]));
    endfunction

    task automatic b_expect(input int s);
        tick();
        check("rr_valid", W'(b_ovalid), 1);
        check("rr_src", W'(b_src), W'(s));
        check("rr_data", b_odata, b_word(s));
        cnt[s]++;
        b_data[s*W +: W] = b_word(s);
    endtask

    initial begin
        a_data = '0; a_valid = '0; a_sel = 2'd2; a_oready = 1'b1;
        b_data = '0; b_valid = '0; b_sel = '0;   b_oready = 1'b1;
        c_data = '0; c_valid = '0; c_sel = '0;   c_oready = 1'b1;
        a_valid = 4'b0100;

        // Reset state, with a request pending on a.
        #1 rst = 1'b1;
        #1;
        check("rst_valid", W'(a_ovalid), 0);
        check("rst_data", a_odata, 0);
        check("rst_src", W'(a_src), 0);
        check("rst_ready", W'(a_ready), 0);
        #1 rst = 1'b0;
        tick();
        a_valid = '0;
        tick();

        // Simple select of channel 2.
        a_data[2*W +: W] = 32'hDEADBEEF;
        a_valid = 4'b0100;
        #1;
        check("sel_ready", W'(a_ready), 4'b0100);
        tick();
        check("sel_valid", W'(a_ovalid), 1);
        check("sel_data", a_odata, 32'hDEADBEEF);
        check("sel_src", W'(a_src), 2);

        // Back-pressure: output held, Sel and data changes ignored.
        a_oready = 1'b0;
        a_sel = 2'd1;
        a_valid = 4'b0010;
        a_data[1*W +: W] = 32'h1111_1111;
        a_data[2*W +: W] = 32'h2222_2222;
        #1;
        check("stall_ready", W'(a_ready), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_valid", W'(a_ovalid), 1);
            check("stall_data", a_odata, 32'hDEADBEEF);
            check("stall_src", W'(a_src), 2);
            check("stall_ready", W'(a_ready), 0);
        end
        a_oready = 1'b1;
        #1;
        check("release_ready", W'(a_ready), 4'b0010);
        tick();
        check("release_data", a_odata, 32'h1111_1111);
        check("release_src", W'(a_src), 1);
        check("release_valid", W'(a_ovalid), 1);

        // Drain; ready on the selected channel even without valid.
        a_valid = '0;
        tick();
        check("drain_valid", W'(a_ovalid), 0);
        check("idle_ready", W'(a_ready), 4'b0010);

        // Reset mid-stream discards a held beat immediately.
        a_sel = 2'd3;
        a_valid = 4'b1000;
        a_data[3*W +: W] = 32'hCAFEF00D;
        a_oready = 1'b0;
        tick();
        check("pre_rst_valid", W'(a_ovalid), 1);
        check("pre_rst_data", a_odata, 32'hCAFEF00D);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", W'(a_ovalid), 0);
        check("mid_rst_data", a_odata, 0);
        check("mid_rst_src", W'(a_src), 0);
        check("mid_rst_ready", W'(a_ready), 0);
        a_valid = '0;
        a_oready = 1'b1;
        #1 rst = 1'b0;
        tick();
        check("post_rst_valid", W'(a_ovalid), 0);

        // Round-robin with all channels requesting: 0,1,2,3,0.
        for (int i = 0; i < 4; i++) begin
            cnt[i] = 0;
            b_data[i*W +: W] = b_word(i);
        end
        b_valid = 4'hF;
        #1;
        check("rr_first_ready", W'(b_ready), 4'b0001);
        b_expect(0);
        b_expect(1);
        b_expect(2);
        b_expect(3);
        b_expect(0);

        // Fairness between channels 1 and 3, then channel 1 alone.
        b_valid = 4'b1010;
        b_expect(1);
        b_expect(3);
        b_expect(1);
        b_expect(3);
        b_valid = 4'b0010;
        b_expect(1);
        b_expect(1);
        b_expect(1);
        b_valid = '0;
        tick();
        check("rr_drain_valid", W'(b_ovalid), 0);

        // N_IN = 3: Sel = 3 grants nothing.
        c_data = {32'hC2C2_C2C2, 32'hC1C1_C1C1, 32'hC0C0_C0C0};
        c_valid = 3'b111;
        c_sel = 2'd3;
        #1;
        check("oor_ready", W'(c_ready), 0);
        tick();
        check("oor_valid", W'(c_ovalid), 0);
        tick();
        check("oor_valid2", W'(c_ovalid), 0);
        c_sel = 2'd2;
        #1;
        check("c_ready", W'(c_ready), 3'b100);
        tick();
        check("c_valid", W'(c_ovalid), 1);
        check("c_data", c_odata, 32'hC2C2_C2C2);
        check("c_src", W'(c_src), 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
